// File: rtl/vga_text_ctrl.sv
// Text-mode VGA controller: a 53x30 character buffer filled from a byte stream,
// scanned in raster order through an external 12x16 font ROM into 640x480@60 RGB.
module vga_text_ctrl #(
  parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR  = 24'h000000,
  parameter int unsigned BLINK_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  output logic [7:0] font_ascii,
  output logic [3:0] font_row,
  output logic [3:0] font_col,
  input  logic       font_data,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] H_ACTIVE  = 10'd640;
  localparam logic [9:0] HS_FIRST  = 10'd656;
  localparam logic [9:0] HS_LAST   = 10'd751;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] V_ACTIVE  = 10'd480;
  localparam logic [9:0] VS_FIRST  = 10'd490;
  localparam logic [9:0] VS_LAST   = 10'd491;
  localparam logic [3:0] PX_LAST   = 4'd11;
  localparam logic [6:0] GRID_COLS = 7'd53;
  localparam logic [5:0] LAST_COL  = 6'd52;
  localparam logic [4:0] LAST_ROW  = 5'd29;
  localparam logic [10:0] LAST_ADDR = 11'd2047;
  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] LINE_FEED = 8'h0A;
  localparam logic [7:0] BACKSPACE = 8'h08;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_t;

  // Raster and cell counters
  logic [9:0]  hcnt_r;
  logic [9:0]  vcnt_r;
  logic [3:0]  px_r;
  logic [6:0]  cx_r;
  logic [7:0]  frame_cnt_r;
  logic        h_wrap_s;
  logic        v_wrap_s;

  // Scan pipeline
  logic [4:0]  cy_s;
  logic        in_grid_s;
  logic        cur_hit_s;
  logic        hs_s;
  logic        vs_s;
  logic        act_s;
  logic [10:0] rd_addr_r;
  logic [3:0]  px1_r;
  logic [3:0]  row1_r;
  logic        hit1_r;
  logic        grid1_r;
  logic        hs1_r;
  logic        vs1_r;
  logic        act1_r;
  logic        hit2_r;
  logic        grid2_r;
  logic        hs2_r;
  logic        vs2_r;
  logic        act2_r;
  logic        cursor_on_s;
  logic        pix_on_s;
  logic [23:0] rgb_r;

  // Character buffer and writer
  logic [7:0]  mem_r [0:2047];
  state_t      state_r;
  logic [10:0] clr_cnt_r;
  logic [5:0]  cur_x_r;
  logic [4:0]  cur_y_r;
  logic        accept_s;
  logic        is_print_s;
  logic        adv_s;
  logic        bksp_s;
  logic [4:0]  next_y_s;
  logic [5:0]  bksp_x_s;
  logic        we_s;
  logic [10:0] wa_s;
  logic [7:0]  wd_s;
  logic        unused_s;

  assign h_wrap_s = (hcnt_r == H_LAST);
  assign v_wrap_s = (vcnt_r == V_LAST);

  // Free-running raster counters; px/cx restart with every line so no divider is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_r      <= 10'd0;
      vcnt_r      <= 10'd0;
      px_r        <= 4'd0;
      cx_r        <= 7'd0;
      frame_cnt_r <= 8'd0;
    end else if (h_wrap_s) begin
      hcnt_r <= 10'd0;
      px_r   <= 4'd0;
      cx_r   <= 7'd0;
      if (v_wrap_s) begin
        vcnt_r      <= 10'd0;
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        vcnt_r <= vcnt_r + 10'd1;
      end
    end else begin
      hcnt_r <= hcnt_r + 10'd1;
      if (px_r == PX_LAST) begin
        px_r <= 4'd0;
        cx_r <= cx_r + 7'd1;
      end else begin
        px_r <= px_r + 4'd1;
      end
    end
  end

  assign cy_s      = vcnt_r[8:4];
  assign in_grid_s = (cx_r < GRID_COLS);
  assign cur_hit_s = in_grid_s && (cx_r == {1'b0, cur_x_r}) && (cy_s == cur_y_r);
  assign hs_s      = !((hcnt_r >= HS_FIRST) && (hcnt_r <= HS_LAST));
  assign vs_s      = !((vcnt_r >= VS_FIRST) && (vcnt_r <= VS_LAST));
  assign act_s     = (hcnt_r < H_ACTIVE) && (vcnt_r < V_ACTIVE);

  // Column 53 (the 4-pixel sliver at x 636..639) is masked so it never shows glyph or cursor
  assign cursor_on_s = hit2_r && (font_row >= 4'd14) && frame_cnt_r[BLINK_BIT];
  assign pix_on_s    = grid2_r && (font_data || cursor_on_s);

  // Three-stage scan: S1 address/decode, S2 buffer read into the font ROM, S3 colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_r  <= 11'd0;
      px1_r      <= 4'd0;
      row1_r     <= 4'd0;
      hit1_r     <= 1'b0;
      grid1_r    <= 1'b0;
      hs1_r      <= 1'b1;
      vs1_r      <= 1'b1;
      act1_r     <= 1'b0;
      font_ascii <= 8'd0;
      font_row   <= 4'd0;
      font_col   <= 4'd0;
      hit2_r     <= 1'b0;
      grid2_r    <= 1'b0;
      hs2_r      <= 1'b1;
      vs2_r      <= 1'b1;
      act2_r     <= 1'b0;
      rgb_r      <= 24'd0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      valid      <= 1'b0;
    end else begin
      rd_addr_r  <= {cy_s, cx_r[5:0]};
      px1_r      <= px_r;
      row1_r     <= vcnt_r[3:0];
      hit1_r     <= cur_hit_s;
      grid1_r    <= in_grid_s;
      hs1_r      <= hs_s;
      vs1_r      <= vs_s;
      act1_r     <= act_s;

      font_ascii <= mem_r[rd_addr_r];
      font_row   <= row1_r;
      font_col   <= px1_r;
      hit2_r     <= hit1_r;
      grid2_r    <= grid1_r;
      hs2_r      <= hs1_r;
      vs2_r      <= vs1_r;
      act2_r     <= act1_r;

      if (!act2_r) begin
        rgb_r <= 24'd0;
      end else if (pix_on_s) begin
        rgb_r <= FG_COLOR;
      end else begin
        rgb_r <= BG_COLOR;
      end
      hsync <= hs2_r;
      vsync <= vs2_r;
      valid <= act2_r;
    end
  end

  assign vga_r = rgb_r[23:16];
  assign vga_g = rgb_r[15:8];
  assign vga_b = rgb_r[7:0];

  assign accept_s   = ch_valid && ch_ready && (state_r == IDLE);
  assign is_print_s = (ch_data >= SPACE) && (ch_data <= 8'h7E);
  assign adv_s      = accept_s && ((is_print_s && (cur_x_r == LAST_COL)) || (ch_data == LINE_FEED));
  assign bksp_s     = accept_s && (ch_data == BACKSPACE) && (cur_x_r != 6'd0);
  assign next_y_s   = (cur_y_r == LAST_ROW) ? 5'd0 : cur_y_r + 5'd1;
  assign bksp_x_s   = cur_x_r - 6'd1;

  // Single buffer write port: printable byte, backspace blank, or one clear step
  always_comb begin
    we_s = 1'b0;
    wa_s = 11'd0;
    wd_s = SPACE;
    case (state_r)
      IDLE: begin
        if (accept_s && is_print_s) begin
          we_s = 1'b1;
          wa_s = {cur_y_r, cur_x_r};
          wd_s = ch_data;
        end else if (bksp_s) begin
          we_s = 1'b1;
          wa_s = {cur_y_r, bksp_x_s};
        end else begin
          we_s = 1'b0;
        end
      end
      CLR_ROW: begin
        we_s = 1'b1;
        wa_s = {cur_y_r, clr_cnt_r[5:0]};
      end
      CLR_ALL: begin
        we_s = 1'b1;
        wa_s = clr_cnt_r;
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Buffer storage; a same-cycle scan read of the written address sees the old byte
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wa_s] <= wd_s;
    end
  end

  // Writer FSM: cursor movement, line advance with row clear, power-up full clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= CLR_ALL;
      clr_cnt_r <= 11'd0;
      cur_x_r   <= 6'd0;
      cur_y_r   <= 5'd0;
      ch_ready  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (adv_s) begin
            cur_x_r   <= 6'd0;
            cur_y_r   <= next_y_s;
            clr_cnt_r <= 11'd0;
            state_r   <= CLR_ROW;
            ch_ready  <= 1'b0;
          end else if (accept_s && is_print_s) begin
            cur_x_r <= cur_x_r + 6'd1;
          end else if (bksp_s) begin
            cur_x_r <= bksp_x_s;
          end
        end
        CLR_ROW: begin
          if (clr_cnt_r[5:0] == LAST_COL) begin
            state_r  <= IDLE;
            ch_ready <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r + 11'd1;
          end
        end
        CLR_ALL: begin
          if (clr_cnt_r == LAST_ADDR) begin
            state_r  <= IDLE;
            ch_ready <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r + 11'd1;
          end
        end
        default: begin
          state_r   <= CLR_ALL;
          clr_cnt_r <= 11'd0;
          ch_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign unused_s = ^frame_cnt_r;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed/random bench for vga_text_ctrl against a cell-level screen model:
// a character grid, cursor and busy window, with pixels derived from raster arithmetic.
module tb_vga_text_ctrl;

  localparam logic [23:0] FG = 24'hE0C020;
  localparam logic [23:0] BG = 24'h102030;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data = 8'd0;
  logic       ch_ready;
  logic [7:0] font_ascii;
  logic [3:0] font_row;
  logic [3:0] font_col;
  logic       font_data;
  logic       hsync;
  logic       vsync;
  logic       valid;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;

  vga_text_ctrl #(.FG_COLOR(FG), .BG_COLOR(BG), .BLINK_BIT(4)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .font_ascii(font_ascii), .font_row(font_row), .font_col(font_col), .font_data(font_data),
    .hsync(hsync), .vsync(vsync), .valid(valid), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  // Synthetic font: spaces blank, other glyphs a code-dependent dot pattern
  function automatic logic font_fn(input logic [7:0] a, input logic [3:0] r, input logic [3:0] c);
    int s;
    s = int'(a) + 3 * int'(r) + 7 * int'(c);
    return (a != 8'h20) && (c < 4'd12) && ((s % 5) < 2);
  endfunction

  assign font_data = font_fn(font_ascii, font_row, font_col);

  int checks = 0;
  int errors = 0;
  int n;          // clock edges since reset release
  int ready_at;   // edge count from which the writer is idle again
  int last_chg;   // last edge that changed buffer or cursor
  int settle;     // outputs before this edge count are not compared
  int vf;         // forced line number, -1 when free-running
  int fc;         // frame count seen by the display
  int mx;
  int my;
  logic last_acc;
  logic [7:0] mbuf [0:29][0:52];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: got %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic reset_model();
    n = 0; ready_at = 2048; last_chg = 0; settle = 0; vf = -1; fc = 0; mx = 0; my = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 53; c++)
        mbuf[r][c] = 8'h20;
  endtask

  task automatic advance_line();
    my = (my == 29) ? 0 : my + 1;
    for (int c = 0; c < 53; c++) mbuf[my][c] = 8'h20;
    ready_at = n + 53;
  endtask

  task automatic apply_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      mbuf[my][mx] = b;
      if (mx == 52) begin mx = 0; advance_line(); end
      else mx = mx + 1;
    end else if (b == 8'h0A) begin
      mx = 0; advance_line();
    end else if (b == 8'h08 && mx > 0) begin
      mx = mx - 1; mbuf[my][mx] = 8'h20;
    end
    last_chg = (ready_at > n) ? ready_at : n;
  endtask

  task automatic check_outputs();
    int p, h, v, cx, row;
    logic on;
    logic [23:0] e;
    chk("ch_ready", 32'(ch_ready), 32'(n >= ready_at));
    if (n >= settle && n >= 2) begin
      p = n - 2; h = p % 800; v = (vf >= 0) ? vf : (p / 800) % 525;
      chk("font_row", 32'(font_row), 32'(v % 16));
      chk("font_col", 32'(font_col), 32'(h % 12));
      if (h < 636 && v < 480 && n >= 2052 && n >= last_chg + 4)
        chk("font_ascii", 32'(font_ascii), 32'(mbuf[v / 16][h / 12]));
    end
    if (n >= settle && n >= 3) begin
      p = n - 3; h = p % 800; v = (vf >= 0) ? vf : (p / 800) % 525;
      chk("hsync", 32'(hsync), 32'(!(h >= 656 && h <= 751)));
      chk("vsync", 32'(vsync), 32'(!(v >= 490 && v <= 491)));
      chk("valid", 32'(valid), 32'(h < 640 && v < 480));
      if (!(h < 640 && v < 480)) begin
        chk("rgb_blank", 32'({vga_r, vga_g, vga_b}), 32'd0);
      end else if (n >= 2052 && n >= last_chg + 4) begin
        cx = h / 12; row = v % 16;
        if (cx >= 53) begin
          e = BG;
        end else begin
          on = font_fn(mbuf[v / 16][cx], 4'(row), 4'(h % 12)) ||
               (cx == mx && v / 16 == my && row >= 14 && ((fc >> 4) & 1) == 1);
          e = on ? FG : BG;
        end
        chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e));
      end
    end
  endtask

  task automatic step();
    logic acc;
    acc = ch_valid & ch_ready;
    @(posedge clk);
    n = n + 1;
    if (acc) begin
      last_acc = 1'b1;
      apply_byte(ch_data);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int k);
    ch_valid = 1'b0;
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic run_until(input int target);
    ch_valid = 1'b0;
    while (n < target) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    ch_valid = 1'b1; ch_data = b; last_acc = 1'b0;
    for (int k = 0; k < 2200 && !last_acc; k++) step();
    chk("accept", 32'(last_acc), 32'd1);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 75) return 8'($urandom_range(32, 126));
    else if (r < 83) return 8'h08;
    else if (r < 87) return 8'h0A;
    else return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    reset_model();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run(700);

    // Reset in the middle of a line (inside the hsync pulse) takes effect at once
    #2 rst = 1'b1;
    #1;
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("rst_ascii", 32'(font_ascii), 32'd0);
    chk("rst_row", 32'(font_row), 32'd0);
    chk("rst_col", 32'(font_col), 32'd0);
    chk("rst_ready", 32'(ch_ready), 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    reset_model();

    // Full clear, then "AB" and three backspaces (the last one a no-op), then glyphs
    send_byte(8'h41); send_byte(8'h42);
    send_byte(8'h08); send_byte(8'h08); send_byte(8'h08);
    chk("bksp_x", 32'(dut.cur_x_r), 32'(mx));
    send_byte(8'h41);
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(33, 126)));
    run_until(10000);

    // New line, then a full row of 'B' that wraps onto the following line
    send_byte(8'h0A);
    for (int i = 0; i < 53; i++) send_byte(8'h42);
    for (int i = 0; i < 30; i++) send_byte(rand_byte());
    run_until(52000);

    // Line feeds until the cursor wraps from row 29 back to a freshly cleared row 0
    for (int i = 0; i < 40; i++) begin
      send_byte(8'h0A);
      if (my == 0) break;
    end
    chk("wrap_y", 32'(my), 32'd0);
    run(60);

    // Revisit row 0 with the blink bit forced on, then off, then the vsync lines
    force dut.frame_cnt_r = 8'h10; fc = 16;
    force dut.vcnt_r = 10'd14; vf = 14; settle = n + 4; run(804);
    force dut.vcnt_r = 10'd13; vf = 13; settle = n + 4; run(804);
    force dut.frame_cnt_r = 8'hEF; fc = 239;
    force dut.vcnt_r = 10'd15; vf = 15; settle = n + 4; run(804);
    force dut.vcnt_r = 10'd489; vf = 489; settle = n + 4; run(804);
    force dut.vcnt_r = 10'd490; vf = 490; settle = n + 4; run(804);
    force dut.vcnt_r = 10'd491; vf = 491; settle = n + 4; run(804);
    force dut.vcnt_r = 10'd492; vf = 492; settle = n + 4; run(804);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
- 640x480@60 text-mode display controller that sits directly upstream of the 12x16 font ROM.
- Holds a character buffer written from a byte stream (keyboard/terminal), with a cursor and auto-clear of new lines.
- Scans the buffer in raster order and drives font_ascii/font_row/font_col to the font ROM.
- Turns the returned font pixel into aligned VGA sync, blank and RGB outputs.

Parameters:
- FG_COLOR, 24'hFFFFFF, RGB of a set font pixel.
- BG_COLOR, 24'h000000, RGB of a clear font pixel.
- BLINK_BIT, 4, frame_cnt bit that gates cursor visibility (toggles every 2^BLINK_BIT frames).

Ports:
- clk  input  1  pixel clock (25 MHz); all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ch_valid  input  1  byte on ch_data offered.
- ch_data  input  8  ASCII byte.
- ch_ready  output  1  controller can accept a byte this cycle.
- font_ascii  output  8  character code to font ROM.
- font_row  output  4  glyph row 0..15.
- font_col  output  4  glyph column 0..11.
- font_data  input  1  font ROM pixel, combinational from the three outputs above.
- hsync  output  1  active-low horizontal sync.
- vsync  output  1  active-low vertical sync.
- valid  output  1  high in the active 640x480 area.
- vga_r, vga_g, vga_b  output  8 each  pixel colour.

Behaviour:
- Clock and reset (decided): one clock clk; rst is asynchronous, active-high.
- Reset values:
  - hcnt = vcnt = 0, cell counters = 0.
  - hsync = vsync = 1, valid = 0, rgb = 0.
  - font outputs = 0, cursor (x, y) = (0, 0), frame_cnt = 0.
  - ch_ready = 0; state = CLR_ALL.
  - A reset mid-operation aborts any clear or write and restarts CLR_ALL.
- Timing:
  - hcnt 0..799: active 0..639, sync low 656..751.
  - vcnt 0..524, increments when hcnt wraps: active 0..479, sync low 490..491.
- Cell mapping:
  - cx/px counters advance with hcnt: px 0..11, cx increments when px wraps.
  - Both counters reset at hcnt = 0; no divider is used.
  - Grid is 53 columns x 30 rows. x 636..639 (cx = 53) always renders BG.
  - cy = vcnt[8:4]; font_row = vcnt[3:0].
- Buffer:
  - 2048 x 8 RAM with synchronous read and one write port.
  - Address = {row[4:0], col[5:0]}.
- Display pipeline, latency 3 (pixel at counters (h, v) appears on outputs 3 cycles later):
  - S1: register read address {cy, cx}, plus px, font_row, cursor-hit and sync/valid.
  - S2: RAM data becomes font_ascii, registered with font_row/font_col = px.
  - S3: register rgb = FG_COLOR if (font_data OR cursor_on) else BG_COLOR.
  - cursor_on = cell matches cursor, AND font_row >= 14, AND frame_cnt[BLINK_BIT].
  - rgb = 0 when valid = 0.
  - hsync, vsync and valid are delayed 3 stages so they align with rgb.
  - frame_cnt (8-bit) increments on the cycle vcnt wraps 524 -> 0.
- Write FSM, states IDLE, CLR_ROW, CLR_ALL:
  - Handshake: a byte is accepted when ch_valid & ch_ready. ch_ready = (state == IDLE), registered.
  - Bytes 0x20..0x7E: write at (x, y), then x+1. If x == 52: x = 0 and advance the line.
  - 0x0A: x = 0, advance the line.
  - 0x08: if x > 0, x = x-1 and write 0x20 at the new x; if x == 0, no-op.
  - All other bytes are accepted and ignored.
- Advance line:
  - y = (y == 29) ? 0 : y+1. Wrap-around, no scrolling.
  - Go to CLR_ROW, which writes 0x20 to cols 0..52 of the new y, one per cycle (53 cycles), then returns to IDLE.
- CLR_ALL writes 0x20 to all 2048 addresses (2048 cycles), then goes to IDLE.
- Simultaneous RAM access: write and scan read of the same address in one cycle returns old data; no stall of the scan.
- Display runs continuously in every state.

Test Plan:
- Reset: assert rst mid-frame -> all outputs at reset values immediately; ch_ready rises exactly 2048 cycles after release; screen fully BG.
- Timing: free-run 2 frames -> hsync low 96 of 800 cycles, vsync low 2 lines of 525, valid high 640x480, outputs aligned 3 cycles after counters.
- Glyph path: send 'A' (0x41) after clear -> font_ascii = 0x41 while scanning cell (0,0); font_col tracks 0..11; rgb = FG exactly where the model font_data = 1.
- Wrap: send 53 x 'B' -> cursor (0, 1); ch_ready low 53 cycles; row 1 all 0x20; row 0 all 0x42.
- Control bytes: "AB", 0x08, 0x08, 0x08 -> cells 0..1 = 0x20, cursor x = 0, third 0x08 no-op. 0x0A at y = 29 -> y = 0, row 0 cleared.
- Cursor blink: cursor cell rows 14-15 FG only while frame_cnt[4] = 1; check across 32 frames (forced frame_cnt allowed); cx = 53 region always BG.
